// File: rtl/mdsa_pkg.sv
// Shared types and index helpers for the shearsort engine.
// Element (r,c) of an N x N matrix lives at flat index r*N+c.
package mdsa_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ROW  = 2'd1,
        COL  = 2'd2,
        DONE = 2'd3
    } state_e;

    function automatic int idx(input int r, input int c, input int n);
        return r * n + c;
    endfunction

    // Returns 1 when row r sorts descending: even rows follow desc,
    // odd rows run opposite to form the snake.
    function automatic logic row_desc(input int r, input logic desc);
        return r[0] ^ desc;
    endfunction

endpackage

// File: rtl/mdsa_oet_layer.sv
// One combinational odd-even transposition layer over N keys.
// parity_i picks the pair set, dir_i=1 orders the pairs descending.
module mdsa_oet_layer #(
    parameter int N  = 8,
    parameter int DW = 32
) (
    input  logic [N*DW-1:0] vec_i,
    input  logic            parity_i,
    input  logic            dir_i,
    output logic [N*DW-1:0] vec_o
);

    logic [DW-1:0] a;
    logic [DW-1:0] b;
    logic          swap;

    always_comb begin
        vec_o = vec_i;
        a     = '0;
        b     = '0;
        swap  = 1'b0;
        for (int i = 0; i < N - 1; i++) begin
            if (i[0] == parity_i) begin
                a    = vec_i[i*DW +: DW];
                b    = vec_i[(i+1)*DW +: DW];
                // strict compare keeps equal keys in place
                swap = dir_i ? (a < b) : (a > b);
                if (swap) begin
                    vec_o[i*DW +: DW]     = b;
                    vec_o[(i+1)*DW +: DW] = a;
                end
            end
        end
    end

endmodule

// File: rtl/mdsa_shearsort_engine.sv
// Shearsort engine: N x N unsigned keys into snake order, one OET layer per clock.
// Optional MDSA_SNAKE_UNFOLD_EN presents the result fully row-major.
module mdsa_shearsort_engine
    import mdsa_pkg::*;
#(
    parameter int N  = 8,
    parameter int DW = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [N*N*DW-1:0] in_data,
    input  logic              in_desc,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [N*N*DW-1:0] out_data,
    output logic              busy
);

    localparam int LOGN = $clog2(N);
    localparam int SW   = LOGN;
    localparam int PW   = $clog2(LOGN + 1);
    localparam int MW   = N * N * DW;

    localparam logic [SW-1:0] STEP_LAST  = SW'(N - 1);
    localparam logic [PW-1:0] PHASE_LAST = PW'(LOGN);

    state_e        state_q, state_d;
    logic [MW-1:0] matrix_q, matrix_d;
    logic [PW-1:0] phase_q, phase_d;
    logic [SW-1:0] step_q, step_d;
    logic          desc_q, desc_d;

    logic [N-1:0][N*DW-1:0] lane_in;
    logic [N-1:0][N*DW-1:0] lane_out;
    logic [N-1:0]           lane_dir;
    logic [MW-1:0]          layer_mat;

    // Lane k carries row k in ROW and column k in COL.
    always_comb begin
        lane_in  = '0;
        lane_dir = '0;
        for (int k = 0; k < N; k++) begin
            for (int j = 0; j < N; j++) begin
                if (state_q == COL)
                    lane_in[k][j*DW +: DW] = matrix_q[idx(j, k, N)*DW +: DW];
                else
                    lane_in[k][j*DW +: DW] = matrix_q[idx(k, j, N)*DW +: DW];
            end
            lane_dir[k] = (state_q == COL) ? desc_q : row_desc(k, desc_q);
        end
    end

    for (genvar k = 0; k < N; k++) begin : g_lane
        mdsa_oet_layer #(
            .N  (N),
            .DW (DW)
        ) u_layer (
            .vec_i    (lane_in[k]),
            .parity_i (step_q[0]),
            .dir_i    (lane_dir[k]),
            .vec_o    (lane_out[k])
        );
    end

    always_comb begin
        layer_mat = matrix_q;
        for (int k = 0; k < N; k++) begin
            for (int j = 0; j < N; j++) begin
                if (state_q == COL)
                    layer_mat[idx(j, k, N)*DW +: DW] = lane_out[k][j*DW +: DW];
                else
                    layer_mat[idx(k, j, N)*DW +: DW] = lane_out[k][j*DW +: DW];
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= IDLE;
            matrix_q <= '0;
            phase_q  <= '0;
            step_q   <= '0;
            desc_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            matrix_q <= matrix_d;
            phase_q  <= phase_d;
            step_q   <= step_d;
            desc_q   <= desc_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        matrix_d = matrix_q;
        phase_d  = phase_q;
        step_d   = step_q;
        desc_d   = desc_q;
        unique case (state_q)
            IDLE: begin
                if (in_valid) begin
                    matrix_d = in_data;
                    desc_d   = in_desc;
                    phase_d  = '0;
                    step_d   = '0;
                    state_d  = ROW;
                end
            end
            ROW: begin
                matrix_d = layer_mat;
                if (step_q == STEP_LAST) begin
                    step_d  = '0;
                    state_d = (phase_q == PHASE_LAST) ? DONE : COL;
                end else begin
                    step_d = step_q + SW'(1);
                end
            end
            COL: begin
                matrix_d = layer_mat;
                if (step_q == STEP_LAST) begin
                    step_d  = '0;
                    phase_d = phase_q + PW'(1);
                    state_d = ROW;
                end else begin
                    step_d = step_q + SW'(1);
                end
            end
            DONE: begin
                if (out_ready)
                    state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        in_ready  = (state_q == IDLE);
        out_valid = (state_q == DONE);
        busy      = (state_q == ROW) || (state_q == COL);
    end

`ifdef MDSA_SNAKE_UNFOLD_EN
    // Odd rows of the snake run backwards; flip them for row-major output.
    always_comb begin
        out_data = matrix_q;
        for (int r = 1; r < N; r += 2) begin
            for (int c = 0; c < N; c++)
                out_data[idx(r, c, N)*DW +: DW] =
                    matrix_q[idx(r, N - 1 - c, N)*DW +: DW];
        end
    end
`else
    assign out_data = matrix_q;
`endif

endmodule

// File: tb/tb_mdsa_shearsort_engine.sv
// Directed and random checks of the shearsort engine at N=4, DW=8.
// Expected snake layouts are written out by hand; random cases use a golden sort.
module tb_mdsa_shearsort_engine;

    localparam int N  = 4;
    localparam int DW = 8;
    localparam int MW = N * N * DW;
    localparam int LAT = 20;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [MW-1:0] in_data = '0;
    logic          in_desc = 1'b0;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic [MW-1:0] out_data;
    logic          busy;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    mdsa_shearsort_engine #(
        .N  (N),
        .DW (DW)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_desc   (in_desc),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .busy      (busy)
    );

    function automatic logic [MW-1:0] pack16(input logic [7:0] e [16]);
        logic [MW-1:0] v;
        v = '0;
        for (int i = 0; i < 16; i++) v[i*8 +: 8] = e[i];
        return v;
    endfunction

    function automatic logic [MW-1:0] view(input logic [MW-1:0] s);
        logic [MW-1:0] v;
        v = s;
`ifdef MDSA_SNAKE_UNFOLD_EN
        for (int r = 1; r < N; r += 2)
            for (int c = 0; c < N; c++)
                v[(r*N+c)*8 +: 8] = s[(r*N+N-1-c)*8 +: 8];
`endif
        return v;
    endfunction

    function automatic logic [MW-1:0] golden(input logic [MW-1:0] m, input logic d);
        logic [7:0] k [16];
        logic [7:0] t;
        logic [MW-1:0] v;
        int pos;
        for (int i = 0; i < 16; i++) k[i] = m[i*8 +: 8];
        for (int i = 0; i < 16; i++)
            for (int j = 0; j < 15 - i; j++)
                if (d ? (k[j] < k[j+1]) : (k[j] > k[j+1])) begin
                    t = k[j]; k[j] = k[j+1]; k[j+1] = t;
                end
        v = '0;
        for (int r = 0; r < N; r++)
            for (int c = 0; c < N; c++) begin
                pos = r * N + ((r % 2 == 0) ? c : N - 1 - c);
                v[(r*N+c)*8 +: 8] = k[pos];
            end
        return v;
    endfunction

    function automatic logic [MW-1:0] reverse_mat();
        logic [MW-1:0] v;
        for (int i = 0; i < 16; i++) v[i*8 +: 8] = 8'(15 - i);
        return v;
    endfunction

    task automatic accept(input logic [MW-1:0] m, input logic d, output int waited);
        waited = 0;
        while (in_ready !== 1'b1 && waited < 50) begin
            @(posedge clk); #1;
            waited++;
        end
        in_data  = m;
        in_desc  = d;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic wait_done(output int lat);
        lat = 0;
        while (out_valid !== 1'b1 && lat < 100) begin
            @(posedge clk); #1;
            lat++;
        end
    endtask

    task automatic take();
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (out_valid !== 1'b0) begin
            errors++; $display("FAIL reset_out_valid got=%b exp=0", out_valid);
        end
        checks++;
        if (busy !== 1'b0) begin
            errors++; $display("FAIL reset_busy got=%b exp=0", busy);
        end
        checks++;
        if (out_data !== '0) begin
            errors++; $display("FAIL reset_out_data got=%h exp=0", out_data);
        end
        rst = 1'b1;
        @(posedge clk); #1;
        checks++;
        if (in_ready !== 1'b1) begin
            errors++; $display("FAIL reset_in_ready got=%b exp=1", in_ready);
        end
    endtask

    task automatic test_reverse_asc();
        logic [7:0] e [16] = '{0,1,2,3, 7,6,5,4, 8,9,10,11, 15,14,13,12};
        logic [MW-1:0] exp_v;
        int w, lat;
        exp_v = view(pack16(e));
        accept(reverse_mat(), 1'b0, w);
        wait_done(lat);
        checks++;
        if (lat !== LAT) begin
            errors++; $display("FAIL asc_latency got=%0d exp=%0d", lat, LAT);
        end
        checks++;
        if (out_data !== exp_v) begin
            errors++; $display("FAIL asc_data got=%h exp=%h", out_data, exp_v);
        end
        take();
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL asc_take got valid=%b ready=%b exp valid=0 ready=1",
                     out_valid, in_ready);
        end
    endtask

    task automatic test_reverse_desc();
        logic [7:0] e [16] = '{15,14,13,12, 8,9,10,11, 7,6,5,4, 0,1,2,3};
        logic [MW-1:0] exp_v;
        int w, lat;
        exp_v = view(pack16(e));
        accept(reverse_mat(), 1'b1, w);
        wait_done(lat);
        checks++;
        if (lat !== LAT) begin
            errors++; $display("FAIL desc_latency got=%0d exp=%0d", lat, LAT);
        end
        checks++;
        if (out_data !== exp_v) begin
            errors++; $display("FAIL desc_data got=%h exp=%h", out_data, exp_v);
        end
        take();
    endtask

    task automatic test_duplicates();
        logic [7:0] e [16] = '{0,0,1,1, 3,3,2,2, 4,4,5,5, 7,7,6,6};
        logic [MW-1:0] m, exp_v, all_aa;
        int w, lat;
        all_aa = {16{8'hAA}};
        accept(all_aa, 1'b0, w);
        wait_done(lat);
        checks++;
        if (lat !== LAT || out_data !== all_aa) begin
            errors++;
            $display("FAIL equal_keys got lat=%0d data=%h exp lat=%0d data=%h",
                     lat, out_data, LAT, all_aa);
        end
        take();
        for (int i = 0; i < 16; i++) m[i*8 +: 8] = 8'((15 - i) / 2);
        exp_v = view(pack16(e));
        accept(m, 1'b0, w);
        wait_done(lat);
        checks++;
        if (lat !== LAT || out_data !== exp_v) begin
            errors++;
            $display("FAIL dup_pairs got lat=%0d data=%h exp lat=%0d data=%h",
                     lat, out_data, LAT, exp_v);
        end
        take();
    endtask

    task automatic test_hold_done();
        logic [7:0] e [16] = '{0,1,2,3, 7,6,5,4, 8,9,10,11, 15,14,13,12};
        logic [7:0] f [16] = '{15,14,13,12, 8,9,10,11, 7,6,5,4, 0,1,2,3};
        logic [MW-1:0] exp_v, exp_next;
        int w, lat, bad;
        exp_v    = view(pack16(e));
        exp_next = view(pack16(f));
        accept(reverse_mat(), 1'b0, w);
        wait_done(lat);
        bad = 0;
        for (int i = 0; i < 10; i++) begin
            in_valid = i[0];
            in_data  = {16{8'h5A}};
            in_desc  = 1'b1;
            @(posedge clk); #1;
            if (out_data !== exp_v || in_ready !== 1'b0 || out_valid !== 1'b1) bad++;
        end
        in_valid = 1'b0;
        checks++;
        if (bad !== 0) begin
            errors++;
            $display("FAIL hold_stable got bad_cycles=%0d data=%h exp 0 data=%h",
                     bad, out_data, exp_v);
        end
        take();
        accept(reverse_mat(), 1'b1, w);
        checks++;
        if (w !== 0) begin
            errors++; $display("FAIL next_accept_wait got=%0d exp=0", w);
        end
        wait_done(lat);
        checks++;
        if (lat !== LAT || out_data !== exp_next) begin
            errors++;
            $display("FAIL next_after_hold got lat=%0d data=%h exp lat=%0d data=%h",
                     lat, out_data, LAT, exp_next);
        end
        take();
    endtask

    task automatic test_reset_mid();
        logic [7:0] f [16] = '{15,14,13,12, 8,9,10,11, 7,6,5,4, 0,1,2,3};
        logic [MW-1:0] exp_v;
        int w, lat;
        exp_v = view(pack16(f));
        accept(reverse_mat(), 1'b0, w);
        repeat (6) begin
            @(posedge clk); #1;
        end
        checks++;
        if (busy !== 1'b1) begin
            errors++; $display("FAIL mid_busy got=%b exp=1", busy);
        end
        rst = 1'b0;
        #1;
        checks++;
        if (out_valid !== 1'b0 || busy !== 1'b0 || out_data !== '0) begin
            errors++;
            $display("FAIL mid_reset got valid=%b busy=%b data=%h exp 0 0 0",
                     out_valid, busy, out_data);
        end
        @(posedge clk); #1;
        rst = 1'b1;
        accept(reverse_mat(), 1'b1, w);
        wait_done(lat);
        checks++;
        if (lat !== LAT || out_data !== exp_v) begin
            errors++;
            $display("FAIL after_reset got lat=%0d data=%h exp lat=%0d data=%h",
                     lat, out_data, LAT, exp_v);
        end
        rst = 1'b0;
        #1;
        checks++;
        if (out_valid !== 1'b0) begin
            errors++; $display("FAIL done_async_reset got=%b exp=0", out_valid);
        end
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_back_to_back();
        logic [MW-1:0] m, exp_v;
        logic d;
        int w, lat;
        for (int n = 0; n < 50; n++) begin
            for (int i = 0; i < 16; i++) m[i*8 +: 8] = 8'($urandom_range(0, 255));
            d = 1'($urandom_range(0, 1));
            exp_v = view(golden(m, d));
            accept(m, d, w);
            checks++;
            if (w !== 0) begin
                errors++; $display("FAIL b2b_accept_%0d got wait=%0d exp=0", n, w);
            end
            wait_done(lat);
            checks++;
            if (lat !== LAT || out_data !== exp_v) begin
                errors++;
                $display("FAIL b2b_%0d got lat=%0d data=%h exp lat=%0d data=%h",
                         n, lat, out_data, LAT, exp_v);
            end
            take();
        end
    endtask

    initial begin
        test_reset();
        test_reverse_asc();
        test_reverse_desc();
        test_duplicates();
        test_hold_done();
        test_reset_mid();
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog expired got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

endmodule
